lsu_bus_master: RTL
===================

Name: lsu_bus_master

Overview:
- CPU-side load/store unit that initiates data-memory accesses on behalf of the MEM stage.
- Converts byte/half/word load and store requests into aligned 32-bit word accesses with byte enables over a req/ack memory port.
- Splits misaligned accesses into two word transactions.
- Sign- or zero-extends load results and flags out-of-range, illegal and timed-out accesses.

Parameters:
- MEM_BYTES, 4096: size of the data memory in bytes; any byte at or beyond this address is out of range.
- TIMEOUT, 255: maximum number of cycles to wait for mem_ack on one access before aborting.

Ports:
- clk  input  1  system clock; everything samples on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  CPU request valid.
- req_ready  output  1  unit can accept a request; high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  input  1  for loads: 1 = zero-extend, 0 = sign-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified.
- resp_valid  output  1  one-cycle pulse when the request completes.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  qualifies resp_valid: out-of-range, illegal size or timeout.
- mem_req  output  1  memory access request.
- mem_we  output  1  write enable for the current access.
- mem_addr  output  32  word-aligned address; bits [1:0] are always 00.
- mem_be  output  4  byte enables; bit i selects byte lane i (little-endian).
- mem_wdata  output  32  lane-aligned write data.
- mem_ack  input  1  memory completes the current access; sampled only while mem_req is high.
- mem_rdata  input  32  read data, valid in the cycle mem_ack is high.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0 except req_ready = 1. State = IDLE; internal counters and registers cleared.
- Reset mid-operation: mem_req drops immediately (asynchronous). Any in-flight request is discarded; no resp_valid is produced for it.
- States: IDLE, ACC1, ACC2, RESP.
- IDLE: a request is accepted on req_valid & req_ready. All request fields are registered at acceptance.
  - n = 1, 2 or 4 bytes from req_size; o = addr[1:0].
  - If req_size = 11, or addr + n - 1 >= MEM_BYTES (unsigned 33-bit compare, so no wrap-around), go to RESP with err = 1. No memory access is issued.
  - Otherwise go to ACC1.
- ACC1: mem_req = 1, mem_addr = {addr[31:2], 2'b00}, mem_be = lanes o .. min(o+n-1, 3).
  - mem_wdata = req_wdata shifted left by 8*o.
  - Request signals are held stable until mem_ack. A lane with mem_be = 0 drives 0.
  - On mem_ack: capture the enabled lanes of mem_rdata. If o + n > 4, go to ACC2; else go to RESP.
- ACC2: mem_addr = first word address + 4, mem_be = lanes 0 .. (o + n - 5).
  - mem_wdata carries the remaining high bytes of req_wdata in lanes 0 upward.
  - On mem_ack, go to RESP.
  - mem_req is low for exactly one cycle between ACC1 and ACC2; the implementation enters ACC2 through a one-cycle gap.
- Timeout: an 8-bit counter restarts at the start of each access and increments every cycle that mem_req is high without mem_ack.
  - When the count reaches TIMEOUT: drop mem_req and go to RESP with err = 1.
  - The first half of a split store that has already completed is not undone.
- RESP: resp_valid = 1 for one cycle, then return to IDLE; req_ready rises the following cycle.
  - resp_rdata is the assembled n bytes, sign- or zero-extended from bit 8n-1. Word loads ignore req_unsigned.
  - resp_rdata = 0 when resp_err = 1 or the request is a store.
- Latency: an aligned access with mem_ack on the first request cycle gives resp_valid 3 cycles after acceptance (accept, ACC1, RESP).
- Back-to-back requests: one request is in flight at a time; there is no queueing.

Test Plan:
- Aligned word load: addr = 0x20, mem_rdata = 0x8899AABB with immediate ack -> mem_be = 1111, mem_addr = 0x20, resp_rdata = 0x8899AABB, resp_err = 0.
- Byte loads: addr = 0x23, mem_rdata = 0x80000000 -> mem_be = 1000. Signed gives resp_rdata = 0xFFFFFF80; with req_unsigned = 1 gives 0x00000080.
- Byte store: addr = 0x21, req_wdata = 0x000000A5 -> single access, mem_we = 1, mem_be = 0010, mem_wdata = 0x0000A500.
- Misaligned word store: addr = 0x1E, req_wdata = 0x11223344 -> access 1 at 0x1C with be = 1100 and wdata = 0x33440000; one idle cycle; access 2 at 0x20 with be = 0011 and wdata = 0x00001122.
- Errors:
  - addr = 0xFFE with size = word -> resp_err = 1, mem_req never asserted.
  - size = 11 -> resp_err = 1.
  - mem_ack held low -> mem_req drops after 255 cycles, resp_err = 1.
- Reset mid-access: assert rst while in ACC1 -> mem_req goes to 0 immediately, no resp_valid, req_ready = 1 after rst is released.

Source files
------------

// File: rtl/lsu_bus_master.sv
// Load/store unit bus master: turns byte/half/word CPU requests into aligned
// 32-bit req/ack memory accesses, splitting misaligned ones into two words.
module lsu_bus_master #(
  parameter int MEM_BYTES = 4096,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC1 = 3'd1,
    GAP  = 3'd2,
    ACC2 = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t      state;
  logic        we_r;
  logic        uns_r;
  logic        split_r;
  logic [1:0]  size_r;
  logic [1:0]  off_r;
  logic [3:0]  be2_r;
  logic [31:0] wdata2_r;
  logic [31:0] data_lo_r;
  logic [7:0]  tcount_r;

  logic [2:0]  n_s;
  logic [3:0]  mask_s;
  logic [31:0] wmask_s;
  logic [7:0]  be8_s;
  logic [63:0] wd64_s;
  logic [32:0] last_s;
  logic        bad_s;
  logic        split_s;
  logic [63:0] raw_s;

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // raw holds the captured lanes of both words; shift the access down to bit 0
  function automatic logic [31:0] extend(input logic [63:0] raw, input logic [1:0] off,
                                         input logic [1:0] size, input logic uns);
    logic [63:0] sh;
    sh = raw >> {off, 3'b000};
    case (size)
      2'b00:   extend = uns ? {24'h000000, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   extend = uns ? {16'h0000, sh[15:0]}   : {{16{sh[15]}}, sh[15:0]};
      default: extend = sh[31:0];
    endcase
  endfunction

  // Request decode: byte count, lane enables for both words, range check
  always_comb begin
    n_s     = 3'd4;
    mask_s  = 4'b1111;
    wmask_s = 32'hFFFF_FFFF;
    case (req_size)
      2'b00: begin
        n_s     = 3'd1;
        mask_s  = 4'b0001;
        wmask_s = 32'h0000_00FF;
      end
      2'b01: begin
        n_s     = 3'd2;
        mask_s  = 4'b0011;
        wmask_s = 32'h0000_FFFF;
      end
      default: begin
        n_s     = 3'd4;
        mask_s  = 4'b1111;
        wmask_s = 32'hFFFF_FFFF;
      end
    endcase
    be8_s   = {4'b0000, mask_s} << req_addr[1:0];
    wd64_s  = {32'h0000_0000, req_wdata & wmask_s} << {req_addr[1:0], 3'b000};
    last_s  = {1'b0, req_addr} + {30'd0, n_s} - 33'd1;
    bad_s   = (req_size == 2'b11) || (last_s >= 33'(MEM_BYTES));
    split_s = ({1'b0, req_addr[1:0]} + n_s) > 3'd4;
    raw_s   = (state == ACC2) ? {mem_rdata & lane_mask(mem_be), data_lo_r}
                              : {32'h0000_0000, mem_rdata & lane_mask(mem_be)};
  end

  // Control FSM with registered bus and response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0000_0000;
      resp_err   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0000_0000;
      mem_be     <= 4'b0000;
      mem_wdata  <= 32'h0000_0000;
      we_r       <= 1'b0;
      uns_r      <= 1'b0;
      split_r    <= 1'b0;
      size_r     <= 2'b00;
      off_r      <= 2'b00;
      be2_r      <= 4'b0000;
      wdata2_r   <= 32'h0000_0000;
      data_lo_r  <= 32'h0000_0000;
      tcount_r   <= 8'd0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            we_r      <= req_we;
            uns_r     <= req_unsigned;
            size_r    <= req_size;
            off_r     <= req_addr[1:0];
            split_r   <= split_s;
            be2_r     <= be8_s[7:4];
            wdata2_r  <= wd64_s[63:32];
            tcount_r  <= 8'd0;
            resp_err  <= 1'b0;
            resp_rdata <= 32'h0000_0000;
            if (bad_s) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              state     <= ACC1;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_be    <= be8_s[3:0];
              mem_wdata <= wd64_s[31:0];
            end
          end
        end
        ACC1, ACC2: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0000;
            mem_wdata <= 32'h0000_0000;
            if (state == ACC1 && split_r) begin
              data_lo_r <= mem_rdata & lane_mask(mem_be);
              state     <= GAP;
            end else begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= we_r ? 32'h0000_0000 : extend(raw_s, off_r, size_r, uns_r);
            end
          end else if (tcount_r == 8'(TIMEOUT - 1)) begin
            // an already-completed first half of a split store stays written
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= 4'b0000;
            mem_wdata  <= 32'h0000_0000;
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= 32'h0000_0000;
          end else begin
            tcount_r <= tcount_r + 8'd1;
          end
        end
        GAP: begin
          mem_req   <= 1'b1;
          mem_we    <= we_r;
          mem_addr  <= mem_addr + 32'd4;
          mem_be    <= be2_r;
          mem_wdata <= wdata2_r;
          tcount_r  <= 8'd0;
          state     <= ACC2;
        end
        RESP: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          busy       <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0000_0000;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          mem_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule
